// File: rtl/line_feed_sched.sv
// line_feed_sched: frame-level sequencer in front of the 4-line-buffer 3x3 window stage.
// Forwards a host pixel stream to the window stage. It throttles the host with line credits so
// that no line buffer is overwritten before the window stage has read it. It pulses a datapath
// reset at frame start and on abort, counts consumed output lines and flags frame completion.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        1-cycle pulse, begins a frame when idle
//   i_abort        abandons the current frame and restarts from CLEAR
//   i_s_data/i_s_valid/o_s_ready   host pixel handshake
//   o_pix_data/o_pix_valid         pixel to window stage (1-cycle latency)
//   o_dp_rst       1-cycle reset pulse to the window stage
//   i_line_done    window stage finished one output line
//   o_busy         high outside IDLE
//   o_frame_done   1-cycle pulse when the last output line is consumed
//   o_lines_out    output lines consumed this frame
//   o_err          sticky protocol error, cleared by i_rst or i_start
module line_feed_sched #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned NUM_LB     = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [7:0]                      i_s_data,
  input  logic                            i_s_valid,
  output logic                            o_s_ready,
  output logic [7:0]                      o_pix_data,
  output logic                            o_pix_valid,
  output logic                            o_dp_rst,
  input  logic                            i_line_done,
  output logic                            o_busy,
  output logic                            o_frame_done,
  output logic [$clog2(IMG_HEIGHT+1)-1:0] o_lines_out,
  output logic                            o_err
);

  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = $clog2(IMG_HEIGHT);
  localparam int unsigned OccW   = $clog2(NUM_LB + 1);
  localparam int unsigned LinesW = $clog2(IMG_HEIGHT + 1);

  localparam logic [ColW-1:0]   ColLast    = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]   RowLast    = RowW'(IMG_HEIGHT - 1);
  localparam logic [OccW-1:0]   OccMax     = OccW'(NUM_LB);
  // The 3x3 window needs three complete lines before an output line can be read.
  localparam logic [OccW-1:0]   OccMinRead = OccW'(3);
  localparam logic [LinesW-1:0] LinesLast  = LinesW'(IMG_HEIGHT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFill,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic [LinesW-1:0]   lines_q, lines_d;
  logic                err_q, err_d;
  logic [7:0]          pix_data_q, pix_data_d;
  logic                pix_valid_q, pix_valid_d;

  logic accept;
  logic line_wr;
  logic last_pix;
  logic ld_state_ok;
  logic ld_ok;
  logic ld_bad;

  always_comb begin
    o_busy       = (state_q != StIdle);
    o_dp_rst     = (state_q == StClear);
    o_frame_done = (state_q == StDone);
    o_s_ready    = (state_q == StFill) && (occ_q < OccMax) && !i_abort;

    accept   = i_s_valid && o_s_ready;
    line_wr  = accept && (col_q == ColLast);
    last_pix = line_wr && (row_q == RowLast);

    // A consume pulse is legal only once lines are flowing, at least three lines are
    // resident, and the frame still has output lines left to produce.
    ld_state_ok = (state_q == StFill) || (state_q == StDrain) || (state_q == StDone);
    ld_ok       = i_line_done && ld_state_ok && (occ_q >= OccMinRead) && (lines_q < LinesLast);
    ld_bad      = i_line_done && !ld_ok;

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    occ_d       = occ_q;
    lines_d     = lines_q;
    err_d       = err_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;

    if (accept) begin
      pix_data_d  = i_s_data;
      pix_valid_d = 1'b1;
      col_d       = (col_q == ColLast) ? '0 : col_q + 1'b1;
      if (line_wr) begin
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end
    end

    unique case ({line_wr, ld_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (ld_ok) begin
      lines_d = lines_q + 1'b1;
    end
    if (ld_bad) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StClear;
          col_d   = '0;
          row_d   = '0;
          occ_d   = '0;
          lines_d = '0;
          err_d   = 1'b0;
        end
      end
      StClear: state_d = StFill;
      StFill: begin
        if (last_pix) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (lines_d == LinesLast) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything except reset; the abort cycle's consume pulse is dropped.
    if (i_abort && (state_q != StIdle)) begin
      state_d     = StClear;
      col_d       = '0;
      row_d       = '0;
      occ_d       = '0;
      lines_d     = '0;
      err_d       = err_q;
      pix_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      occ_q       <= '0;
      lines_q     <= '0;
      err_q       <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      occ_q       <= occ_d;
      lines_q     <= lines_d;
      err_q       <= err_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign o_pix_data  = pix_data_q;
  assign o_pix_valid = pix_valid_q;
  assign o_lines_out = lines_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_line_feed_sched.sv
// Testbench for line_feed_sched (IMG_WIDTH=8, IMG_HEIGHT=6, NUM_LB=4).
// The driver pushes every pixel it expects to be accepted into a queue; a monitor pops and
// compares whenever the DUT presents a forwarded pixel.
module tb_line_feed_sched;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned LB = 4;
  localparam int unsigned LW = $clog2(H + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          dp_rst;
  logic          line_done = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] lines_out;
  logic          err;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  line_feed_sched #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NUM_LB    (LB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_s_data    (s_data),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .o_pix_data  (pix_data),
    .o_pix_valid (pix_valid),
    .o_dp_rst    (dp_rst),
    .i_line_done (line_done),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_lines_out (lines_out),
    .o_err       (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One cycle of stimulus: inputs change on the falling edge, checks follow 1 time unit later.
  task automatic drive(input logic v, input logic [7:0] d, input logic ld,
                       input logic st, input logic ab);
    @(negedge clk);
    s_valid   = v;
    s_data    = d;
    line_done = ld;
    start     = st;
    abort     = ab;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  // Offer one pixel that must be accepted this cycle.
  task automatic send(input int i, input logic ld);
    drive(1'b1, pix(i), ld, 1'b0, 1'b0);
    chk("ready_during_stream", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(pix(i));
  endtask

  // Monitor: every forwarded pixel must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && pix_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pix_unexpected: got %0d, expected no pixel", pix_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (pix_data !== e) begin
          fails++;
          $display("FAIL pix_data: got %0d, expected %0d", pix_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset and start.
    repeat (3) idle();
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dp_rst", {31'd0, dp_rst}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_lines_out", 32'(lines_out), 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_dp_rst", {31'd0, dp_rst}, 32'd1);
    chk("clear_ready", {31'd0, s_ready}, 32'd0);
    idle();
    chk("fill_dp_rst_low", {31'd0, dp_rst}, 32'd0);
    chk("fill_ready", {31'd0, s_ready}, 32'd1);

    // Test 2: four lines fill all credits.
    for (int i = 0; i < 32; i++) send(i, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("occ_full_ready", {31'd0, s_ready}, 32'd0);
    chk("occ_full_lines", 32'(lines_out), 32'd0);

    // Test 3: one consumed line returns a credit.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("credit_ready", {31'd0, s_ready}, 32'd1);
    chk("credit_lines", 32'(lines_out), 32'd1);
    chk("credit_err", {31'd0, err}, 32'd0);

    // Test 4: finish the frame, with one consume coincident with a line wrap.
    for (int i = 32; i < 40; i++) send(i, (i == 39));
    idle();
    chk("coinc_lines", 32'(lines_out), 32'd2);
    chk("coinc_occ_ready", {31'd0, s_ready}, 32'd1);
    for (int i = 40; i < 48; i++) send(i, 1'b0);
    idle();
    chk("drain_ready", {31'd0, s_ready}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("drain_lines3", 32'(lines_out), 32'd3);
    chk("drain_no_done", {31'd0, frame_done}, 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("done_lines4", 32'(lines_out), 32'd4);
    idle();
    chk("after_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("after_done_busy", {31'd0, busy}, 32'd0);
    chk("after_done_err", {31'd0, err}, 32'd0);
    chk("after_done_lines", 32'(lines_out), 32'd4);

    // Consume pulse in IDLE is an error; start clears it.
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("idle_ld_err", {31'd0, err}, 32'd1);
    chk("idle_ld_lines", 32'(lines_out), 32'd4);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    chk("start_clr_err", {31'd0, err}, 32'd0);
    chk("start_clr_lines", 32'(lines_out), 32'd0);
    chk("start2_dp_rst", {31'd0, dp_rst}, 32'd1);
    idle();

    // Test 5: premature consume after two lines.
    for (int i = 0; i < 16; i++) send(i + 100, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("early_ld_err", {31'd0, err}, 32'd1);
    chk("early_ld_lines", 32'(lines_out), 32'd0);
    // occ must still be 2: exactly two more lines fill the credits.
    for (int i = 16; i < 32; i++) send(i + 100, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("early_occ2_full", {31'd0, s_ready}, 32'd0);

    // Abort from a credit-stalled FILL.
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("abort1_ready", {31'd0, s_ready}, 32'd0);
    idle();
    chk("abort1_dp_rst", {31'd0, dp_rst}, 32'd1);
    idle();
    chk("abort1_ready_after", {31'd0, s_ready}, 32'd1);

    // Test 6: abort mid-line at col 5, row 2.
    for (int i = 0; i < 21; i++) send(i + 200, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("abort_ready", {31'd0, s_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    idle();
    chk("abort_dp_rst", {31'd0, dp_rst}, 32'd1);
    chk("abort_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("abort_lines", 32'(lines_out), 32'd0);
    idle();
    chk("abort_fill_ready", {31'd0, s_ready}, 32'd1);

    // Clean frame after abort: consumes coincide with the wraps of rows 3..5.
    for (int i = 0; i < 24; i++) send(i + 300, 1'b0);
    for (int i = 24; i < 48; i++) send(i + 300, ((i % 8) == 7));
    idle();
    chk("clean_drain_ready", {31'd0, s_ready}, 32'd0);
    chk("clean_lines3", 32'(lines_out), 32'd3);
    chk("clean_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    chk("clean_frame_done", {31'd0, frame_done}, 32'd1);
    chk("clean_lines4", 32'(lines_out), 32'd4);
    idle();
    chk("clean_idle_busy", {31'd0, busy}, 32'd0);
    chk("clean_done_low", {31'd0, frame_done}, 32'd0);

    repeat (2) idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
